// File: rtl/tdm_demux_pkg.sv
// ---------------------------------------------------------------------------
// tdm_demux_pkg : shared types and constants for the TDM demux    (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package tdm_demux_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CH0  = 2'd1,
    CH1  = 2'd2
  } state_t;

  // Bit-counter width able to hold 0..w-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_shift.sv
// ---------------------------------------------------------------------------
// sipo_shift : MSB-first serial-in parallel-out shift register     (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // clr together with shift_en starts a fresh word with din as its first bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (shift_en) begin
      if (clr) begin
        q <= WIDTH'(din);
      end else begin
        q <= (q << 1) | WIDTH'(din);
      end
    end else if (clr) begin
      q <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdm_demux2.sv
// ---------------------------------------------------------------------------
// tdm_demux2 : two-channel TDM serial demultiplexer with resync    (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tdm_demux2
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0_data,
  output logic             ch0_valid,
  output logic [WIDTH-1:0] ch1_data,
  output logic             ch1_valid,
  output logic             sel,
  output logic             frame_err
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic               shift_en;
  logic               clr;
  logic               load0;
  logic               load1;
  logic               err;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   word;

  sipo_shift #(
    .WIDTH (WIDTH)
  ) u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .clr      (clr),
    .din      (din),
    .q        (q)
  );

  // Completed word including the bit sampled on this edge (zero-latency load).
  assign word = (q << 1) | WIDTH'(din);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shift_en = 1'b0;
    clr      = 1'b0;
    load0    = 1'b0;
    load1    = 1'b0;
    err      = 1'b0;
    if (en) begin
      // A sync always restarts channel 0, even on the bit that would finish a word.
      if (frame_sync) begin
        shift_en = 1'b1;
        clr      = 1'b1;
        cnt_nx   = ONE;
        state_nx = CH0;
        err      = (state != IDLE);
      end else begin
        case (state)
          IDLE: begin
            state_nx = IDLE;
          end
          CH0: begin
            shift_en = 1'b1;
            if (cnt == LAST) begin
              load0    = 1'b1;
              cnt_nx   = '0;
              state_nx = CH1;
            end else begin
              cnt_nx = cnt + ONE;
            end
          end
          CH1: begin
            shift_en = 1'b1;
            if (cnt == LAST) begin
              load1    = 1'b1;
              cnt_nx   = '0;
              state_nx = IDLE;
            end else begin
              cnt_nx = cnt + ONE;
            end
          end
          default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch0_data  <= '0;
      ch1_data  <= '0;
      ch0_valid <= 1'b0;
      ch1_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ch0_valid <= load0;
      ch1_valid <= load1;
      frame_err <= err;
      if (load0) begin
        ch0_data <= word;
      end
      if (load1) begin
        ch1_data <= word;
      end
    end
  end

  assign sel = (state == CH1);

endmodule

`default_nettype wire
